unfunnel_buffered: RTL

//  Inverse of the buffered funnel. Takes one serialized portal pipe (16-bit header + payload)
//  and dispatches each message to one of funnelWidth output pipes, selected by a header field.

---
 rtl/unfunnel_buffered.sv | 81 ++++++++
 1 files changed

// File: rtl/unfunnel_buffered.sv
// unfunnel_buffered: dispatches one serialized portal pipe to funnelWidth
// output pipes through a small FIFO, discarding messages with a bad dest.
module unfunnel_buffered #(
   parameter int funnelWidth = 1,
   parameter int dataWidth   = 16 + 128,
   parameter int depth       = 2
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic                   in_enq__ENA,
   input  logic [dataWidth-1:0]   in_enq_v,
   output logic                   in_enq__RDY,
   output logic [funnelWidth-1:0] out_enq__ENA,
   output logic [dataWidth-1:0]   out_enq_v,
   input  logic [funnelWidth-1:0] out_enq__RDY,
   output logic [15:0]            dropCount
);

   localparam int AW = $clog2(depth);
   localparam int CW = $clog2(depth) + 1;

   logic [dataWidth-1:0] mem [depth];
   logic [AW-1:0]        rd_ptr;
   logic [AW-1:0]        wr_ptr;
   logic [CW-1:0]        count;
   logic [15:0]          drop_cnt;
   logic [7:0]           dest;
   logic                 valid;
   logic                 in_range;
   logic                 push;
   logic                 pop;
   logic                 drop;

   assign out_enq_v   = mem[rd_ptr];
   assign dest        = out_enq_v[dataWidth-1 -: 8];
   assign valid       = (count != '0);
   assign in_range    = (int'(dest) < funnelWidth);
   assign in_enq__RDY = nRST && (count != CW'(depth));
   assign push        = in_enq__ENA && in_enq__RDY;
   assign drop        = valid && !in_range;
   assign pop         = drop || (|out_enq__ENA);
   assign dropCount   = drop_cnt;

   always_comb begin
      out_enq__ENA = '0;
      for (int i = 0; i < funnelWidth; i++) begin
         if (valid && int'(dest) == i) begin
            out_enq__ENA[i] = out_enq__RDY[i];
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         drop_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
         if (drop && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= in_enq_v;
   end

   always_ff @(posedge CLK) begin
      if (nRST) assert (!in_enq__ENA || in_enq__RDY);
   end

endmodule
